pc_sequencer: RTL and testbench



---
 rtl/pc_pkg.sv | 25 ++
 rtl/pc_sequencer_if.sv | 50 +++++
 rtl/pc_target_calc.sv | 62 ++++++
 rtl/pc_sequencer.sv | 136 +++++++++++++
 tb/tb_pc_sequencer.sv | 306 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/pc_pkg.sv
// -----------------------------------------------------------------------------
// pc_pkg
// Shared types and constants for the program-counter sequencer slice.
//   redirect_kind_t : encoding of the redirect_kind request field
//   pc_state_t      : redirect FSM states (IDLE, PENDING)
//   PC_DEFAULT_RESET_VECTOR : MIPS boot ROM vector used as the default reset PC
// No ports (package).
// -----------------------------------------------------------------------------
package pc_pkg;

    typedef enum logic [1:0] {
        BRANCH = 2'd0,   // PC-relative: pc_plus + sign-extended byte offset
        JUMP   = 2'd1,   // region jump: keep upper REGION_BITS of pc_plus
        JREG   = 2'd2,   // absolute jump to a register value
        RSVD   = 2'd3    // reserved encoding, never accepted
    } redirect_kind_t;

    typedef enum logic {
        IDLE    = 1'b0,
        PENDING = 1'b1   // delay slot is at pc_out, target is latched
    } pc_state_t;

    localparam logic [31:0] PC_DEFAULT_RESET_VECTOR = 32'hBFC0_0000;

endpackage

// File: rtl/pc_sequencer_if.sv
// -----------------------------------------------------------------------------
// pc_sequencer_if
// Request/response bundle between the control unit / ALU target path and the
// PC sequencer.
//   Requests  (master -> slave): pc_en, redirect_valid, redirect_kind[1:0],
//                                redirect_operand[ADDR_W-1:0]
//   Responses (slave -> master): pc_out, pc_plus, in_delay_slot, pc_is_zero,
//                                align_fault
// Modports: master (requester side), slave (the sequencer).
// -----------------------------------------------------------------------------
interface pc_sequencer_if #(
    parameter int ADDR_W = 32
) ();

    logic              pc_en;
    logic              redirect_valid;
    logic [1:0]        redirect_kind;
    logic [ADDR_W-1:0] redirect_operand;

    logic [ADDR_W-1:0] pc_out;
    logic [ADDR_W-1:0] pc_plus;
    logic              in_delay_slot;
    logic              pc_is_zero;
    logic              align_fault;

    modport master (
        output pc_en,
        output redirect_valid,
        output redirect_kind,
        output redirect_operand,
        input  pc_out,
        input  pc_plus,
        input  in_delay_slot,
        input  pc_is_zero,
        input  align_fault
    );

    modport slave (
        input  pc_en,
        input  redirect_valid,
        input  redirect_kind,
        input  redirect_operand,
        output pc_out,
        output pc_plus,
        output in_delay_slot,
        output pc_is_zero,
        output align_fault
    );

endinterface

// File: rtl/pc_target_calc.sv
// -----------------------------------------------------------------------------
// pc_target_calc
// Purely combinational redirect target and alignment computation.
// Ports:
//   i_pc_plus      : current PC plus one instruction (delay-slot address)
//   i_kind         : redirect kind (BRANCH / JUMP / JREG / RSVD)
//   i_operand      : offset, region target or absolute target depending on kind
//   o_target       : computed redirect target
//   o_kind_valid   : kind is a usable redirect (RSVD is not)
//   o_misaligned   : target has nonzero bits below the instruction size
// -----------------------------------------------------------------------------
module pc_target_calc
    import pc_pkg::*;
#(
    parameter int ADDR_W      = 32,
    parameter int REGION_BITS = 4,
    parameter int INSTR_BYTES = 4
) (
    input  logic [ADDR_W-1:0] i_pc_plus,
    input  redirect_kind_t    i_kind,
    input  logic [ADDR_W-1:0] i_operand,
    output logic [ADDR_W-1:0] o_target,
    output logic              o_kind_valid,
    output logic              o_misaligned
);

    // INSTR_BYTES is a power of two, so INSTR_BYTES-1 masks the byte-offset bits.
    localparam logic [ADDR_W-1:0] ALIGN_MASK = ADDR_W'(INSTR_BYTES - 1);

    // Target selection per redirect kind; relative branches are based on the
    // delay-slot address, which is what MIPS offsets are measured from.
    always_comb begin
        o_target     = {ADDR_W{1'b0}};
        o_kind_valid = 1'b0;
        case (i_kind)
            BRANCH: begin
                o_target     = i_pc_plus + i_operand;
                o_kind_valid = 1'b1;
            end
            JUMP: begin
                o_target     = {i_pc_plus[ADDR_W-1 -: REGION_BITS],
                                i_operand[ADDR_W-REGION_BITS-1:0]};
                o_kind_valid = 1'b1;
            end
            JREG: begin
                o_target     = i_operand;
                o_kind_valid = 1'b1;
            end
            RSVD: begin
                o_target     = {ADDR_W{1'b0}};
                o_kind_valid = 1'b0;
            end
            default: begin
                o_target     = {ADDR_W{1'b0}};
                o_kind_valid = 1'b0;
            end
        endcase
    end

    assign o_misaligned = ((o_target & ALIGN_MASK) != {ADDR_W{1'b0}});

endmodule

// File: rtl/pc_sequencer.sv
// -----------------------------------------------------------------------------
// pc_sequencer
// Program-counter sequencer for the MIPS core: sequential increment, stall,
// and BRANCH / JUMP / JREG redirects with one architectural delay slot.
// Ports:
//   clk    : system clock
//   reset  : synchronous active-high reset (highest priority)
//   bus    : pc_sequencer_if.slave
//              in : pc_en, redirect_valid, redirect_kind, redirect_operand
//              out: pc_out (registered), pc_plus, in_delay_slot (registered
//                   state), pc_is_zero, align_fault (registered pulse)
// Build option:
//   PC_ALIGN_CHECK_EN : when defined, redirects to a target that is not
//                       instruction-aligned are rejected and align_fault pulses
//                       for one cycle; when undefined align_fault stays 0.
// -----------------------------------------------------------------------------
module pc_sequencer
    import pc_pkg::*;
#(
    parameter int          ADDR_W       = 32,
    parameter logic [31:0] RESET_VECTOR = PC_DEFAULT_RESET_VECTOR,
    parameter int          REGION_BITS  = 4,
    parameter int          INSTR_BYTES  = 4
) (
    input  logic           clk,
    input  logic           reset,
    pc_sequencer_if.slave  bus
);

    localparam logic [ADDR_W-1:0] RESET_PC = ADDR_W'(RESET_VECTOR);
    localparam logic [ADDR_W-1:0] INCR     = ADDR_W'(INSTR_BYTES);

`ifdef PC_ALIGN_CHECK_EN
    localparam logic ALIGN_CHECK = 1'b1;
`else
    localparam logic ALIGN_CHECK = 1'b0;
`endif

    pc_state_t         r_state;
    logic [ADDR_W-1:0] r_pc;
    logic [ADDR_W-1:0] r_target;
    logic              r_align_fault;

    pc_state_t         w_state_nxt;
    logic [ADDR_W-1:0] w_pc_nxt;
    logic [ADDR_W-1:0] w_target_nxt;
    logic              w_align_fault_nxt;

    logic [ADDR_W-1:0] w_pc_plus;
    logic [ADDR_W-1:0] w_calc_target;
    logic              w_kind_valid;
    logic              w_misaligned;
    logic              w_reject;

    // Natural wrap-around: the top address plus one instruction is address 0.
    assign w_pc_plus = r_pc + INCR;

    pc_target_calc #(
        .ADDR_W      (ADDR_W),
        .REGION_BITS (REGION_BITS),
        .INSTR_BYTES (INSTR_BYTES)
    ) u_target_calc (
        .i_pc_plus    (w_pc_plus),
        .i_kind       (redirect_kind_t'(bus.redirect_kind)),
        .i_operand    (bus.redirect_operand),
        .o_target     (w_calc_target),
        .o_kind_valid (w_kind_valid),
        .o_misaligned (w_misaligned)
    );

    // With the check disabled this is constant 0 and the fault register never sets.
    assign w_reject = ALIGN_CHECK & w_misaligned;

    // Redirect FSM next-state, next-PC, target latch and fault pulse.
    always_comb begin
        w_state_nxt       = r_state;
        w_pc_nxt          = r_pc;
        w_target_nxt      = r_target;
        w_align_fault_nxt = 1'b0;
        case (r_state)
            IDLE: begin
                if (bus.pc_en) begin
                    // Whether or not a redirect is taken, the next fetch is the
                    // sequential instruction (the delay slot when redirecting).
                    w_pc_nxt = w_pc_plus;
                    if (bus.redirect_valid && w_kind_valid) begin
                        if (w_reject) begin
                            w_align_fault_nxt = 1'b1;
                        end else begin
                            w_target_nxt = w_calc_target;
                            w_state_nxt  = PENDING;
                        end
                    end else begin
                        w_state_nxt = IDLE;
                    end
                end else begin
                    w_pc_nxt = r_pc;
                end
            end
            PENDING: begin
                // Redirect requests here are branches in a delay slot: dropped.
                if (bus.pc_en) begin
                    w_pc_nxt    = r_target;
                    w_state_nxt = IDLE;
                end else begin
                    w_state_nxt = PENDING;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // State, PC, latched target and fault pulse registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state       <= IDLE;
            r_pc          <= RESET_PC;
            r_target      <= {ADDR_W{1'b0}};
            r_align_fault <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            r_pc          <= w_pc_nxt;
            r_target      <= w_target_nxt;
            r_align_fault <= w_align_fault_nxt;
        end
    end

    assign bus.pc_out        = r_pc;
    assign bus.pc_plus       = w_pc_plus;
    assign bus.in_delay_slot = (r_state == PENDING);
    assign bus.pc_is_zero    = (r_pc == {ADDR_W{1'b0}});
    assign bus.align_fault   = r_align_fault;

endmodule

// File: tb/tb_pc_sequencer.sv
// Self-checking bench for pc_sequencer (32-bit, default parameters).
module tb_pc_sequencer;
    import pc_pkg::*;

`ifdef PC_ALIGN_CHECK_EN
    localparam bit CHK = 1'b1;
`else
    localparam bit CHK = 1'b0;
`endif

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] plus;
        logic        ds;
        logic        zero;
        logic        fault;
    } snap_t;

    logic clk = 1'b0;
    logic reset;
    int   errors = 0;
    int   checks = 0;

    snap_t exp_q[$];
    snap_t obs_q[$];

    // reference model state
    logic [31:0] m_pc   = 32'h0;
    logic        m_pend = 1'b0;
    logic [31:0] m_tgt  = 32'h0;
    logic        m_fault = 1'b0;

    always #5 clk = ~clk;

    pc_sequencer_if #(.ADDR_W(32)) bus ();

    pc_sequencer #(
        .ADDR_W       (32),
        .RESET_VECTOR (32'hBFC0_0000),
        .REGION_BITS  (4),
        .INSTR_BYTES  (4)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    // Drive one cycle, predict the result, capture the DUT after the edge.
    task automatic drive(input logic rst, input logic en, input logic rv,
                         input logic [1:0] kind, input logic [31:0] op);
        logic [31:0] plus;
        logic [31:0] t;
        snap_t e;
        snap_t o;
        reset                = rst;
        bus.pc_en            = en;
        bus.redirect_valid   = rv;
        bus.redirect_kind    = kind;
        bus.redirect_operand = op;
        plus = m_pc + 32'd4;
        t    = 32'h0;
        if (rst) begin
            m_pc = 32'hBFC0_0000; m_pend = 1'b0; m_tgt = 32'h0; m_fault = 1'b0;
        end else begin
            m_fault = 1'b0;
            if (en) begin
                if (m_pend) begin
                    m_pc = m_tgt; m_pend = 1'b0;
                end else begin
                    if (rv && kind != 2'd3) begin
                        case (kind)
                            2'd0:    t = plus + op;
                            2'd1:    t = {plus[31:28], op[27:0]};
                            default: t = op;
                        endcase
                        if (CHK && t[1:0] != 2'b00) m_fault = 1'b1;
                        else begin m_tgt = t; m_pend = 1'b1; end
                    end
                    m_pc = plus;
                end
            end
        end
        e = '{m_pc, m_pc + 32'd4, m_pend, (m_pc == 32'h0), m_fault};
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        o = '{bus.pc_out, bus.pc_plus, bus.in_delay_slot, bus.pc_is_zero, bus.align_fault};
        obs_q.push_back(o);
    endtask

    task automatic test_reset();
        snap_t e, o;
        drive(1'b1, 1'b0, 1'b0, 2'd0, 32'h0);
        drive(1'b1, 1'b1, 1'b1, 2'd2, 32'h1234_5678);
        checks++;
        if (bus.pc_out !== 32'hBFC0_0000 || bus.pc_plus !== 32'hBFC0_0004 ||
            bus.in_delay_slot !== 1'b0 || bus.align_fault !== 1'b0) begin
            errors++;
            $display("FAIL reset_values: got pc=%h plus=%h ds=%b fault=%b, expected BFC00000/BFC00004/0/0",
                     bus.pc_out, bus.pc_plus, bus.in_delay_slot, bus.align_fault);
        end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
            if (o !== e) begin errors++; $display("FAIL reset: got %h expected %h", o, e); end
        end
    endtask

    task automatic test_sequential();
        snap_t e, o;
        for (int i = 0; i < 3; i++) drive(1'b0, 1'b1, 1'b0, 2'd0, 32'h0);
        checks++;
        if (bus.pc_out !== 32'hBFC0_000C || bus.in_delay_slot !== 1'b0) begin
            errors++;
            $display("FAIL seq_third: got pc=%h ds=%b expected BFC0000C/0", bus.pc_out, bus.in_delay_slot);
        end
        drive(1'b0, 1'b0, 1'b0, 2'd0, 32'h0);
        drive(1'b0, 1'b1, 1'b0, 2'd0, 32'h0);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
            if (o !== e) begin errors++; $display("FAIL sequential: got %h expected %h", o, e); end
        end
    endtask

    task automatic test_branch();
        snap_t e, o;
        drive(1'b0, 1'b1, 1'b1, 2'd0, 32'hFFFF_FFF0);
        checks++;
        if (bus.pc_out !== 32'hBFC0_0014 || bus.in_delay_slot !== 1'b1) begin
            errors++;
            $display("FAIL branch_slot: got pc=%h ds=%b expected BFC00014/1", bus.pc_out, bus.in_delay_slot);
        end
        // branch in delay slot with a changed operand must be dropped
        drive(1'b0, 1'b1, 1'b1, 2'd0, 32'h0000_0040);
        checks++;
        if (bus.pc_out !== 32'hBFC0_0004) begin
            errors++;
            $display("FAIL branch_target: got pc=%h expected BFC00004", bus.pc_out);
        end
        for (int i = 0; i < 7; i++) drive(1'b0, 1'b1, 1'b0, 2'd0, 32'h0);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
            if (o !== e) begin errors++; $display("FAIL branch: got %h expected %h", o, e); end
        end
    endtask

    task automatic test_jump();
        snap_t e, o;
        drive(1'b0, 1'b1, 1'b1, 2'd1, 32'h0000_0100);
        drive(1'b0, 1'b1, 1'b0, 2'd0, 32'h0);
        checks++;
        if (bus.pc_out !== 32'hB000_0100 || bus.in_delay_slot !== 1'b0) begin
            errors++;
            $display("FAIL jump_target: got pc=%h ds=%b expected B0000100/0", bus.pc_out, bus.in_delay_slot);
        end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
            if (o !== e) begin errors++; $display("FAIL jump: got %h expected %h", o, e); end
        end
    endtask

    task automatic test_jreg_stall();
        snap_t e, o;
        drive(1'b0, 1'b1, 1'b1, 2'd2, 32'h0000_0000);
        for (int i = 0; i < 3; i++) drive(1'b0, 1'b0, 1'b1, 2'd0, 32'h0000_0080);
        checks++;
        if (bus.pc_out !== 32'hB000_0104 || bus.in_delay_slot !== 1'b1) begin
            errors++;
            $display("FAIL stall_hold: got pc=%h ds=%b expected B0000104/1", bus.pc_out, bus.in_delay_slot);
        end
        drive(1'b0, 1'b1, 1'b0, 2'd0, 32'h0);
        checks++;
        if (bus.pc_out !== 32'h0 || bus.pc_is_zero !== 1'b1) begin
            errors++;
            $display("FAIL jreg_zero: got pc=%h zero=%b expected 00000000/1", bus.pc_out, bus.pc_is_zero);
        end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
            if (o !== e) begin errors++; $display("FAIL jreg_stall: got %h expected %h", o, e); end
        end
    endtask

    task automatic test_ignored();
        snap_t e, o;
        drive(1'b0, 1'b0, 1'b1, 2'd2, 32'h0000_0080);   // pc_en low: not accepted
        drive(1'b0, 1'b1, 1'b1, 2'd3, 32'h0000_0080);   // reserved kind
        drive(1'b0, 1'b1, 1'b0, 2'd0, 32'h0);
        checks++;
        if (bus.pc_out !== 32'h0000_0008 || bus.in_delay_slot !== 1'b0) begin
            errors++;
            $display("FAIL ignored: got pc=%h ds=%b expected 00000008/0", bus.pc_out, bus.in_delay_slot);
        end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
            if (o !== e) begin errors++; $display("FAIL ignored_sb: got %h expected %h", o, e); end
        end
    endtask

    task automatic test_reset_pending();
        snap_t e, o;
        drive(1'b0, 1'b1, 1'b1, 2'd2, 32'h1234_5678);
        drive(1'b1, 1'b1, 1'b0, 2'd0, 32'h0);
        checks++;
        if (bus.pc_out !== 32'hBFC0_0000 || bus.in_delay_slot !== 1'b0) begin
            errors++;
            $display("FAIL reset_pending: got pc=%h ds=%b expected BFC00000/0", bus.pc_out, bus.in_delay_slot);
        end
        drive(1'b0, 1'b1, 1'b0, 2'd0, 32'h0);
        drive(1'b0, 1'b1, 1'b0, 2'd0, 32'h0);
        checks++;
        if (bus.pc_out !== 32'hBFC0_0008) begin
            errors++;
            $display("FAIL stale_target: got pc=%h expected BFC00008", bus.pc_out);
        end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
            if (o !== e) begin errors++; $display("FAIL reset_pending_sb: got %h expected %h", o, e); end
        end
    endtask

    task automatic test_wrap();
        snap_t e, o;
        drive(1'b0, 1'b1, 1'b1, 2'd2, 32'hFFFF_FFFC);
        drive(1'b0, 1'b1, 1'b0, 2'd0, 32'h0);
        checks++;
        if (bus.pc_out !== 32'hFFFF_FFFC || bus.pc_plus !== 32'h0) begin
            errors++;
            $display("FAIL wrap_top: got pc=%h plus=%h expected FFFFFFFC/00000000", bus.pc_out, bus.pc_plus);
        end
        drive(1'b0, 1'b1, 1'b0, 2'd0, 32'h0);
        checks++;
        if (bus.pc_out !== 32'h0 || bus.pc_is_zero !== 1'b1 || bus.align_fault !== 1'b0) begin
            errors++;
            $display("FAIL wrap_zero: got pc=%h zero=%b fault=%b expected 00000000/1/0",
                     bus.pc_out, bus.pc_is_zero, bus.align_fault);
        end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
            if (o !== e) begin errors++; $display("FAIL wrap: got %h expected %h", o, e); end
        end
    endtask

    task automatic test_back_to_back();
        snap_t e, o;
        drive(1'b0, 1'b1, 1'b1, 2'd0, 32'h0000_0008);   // 0 -> slot 4, target 0xC
        drive(1'b0, 1'b1, 1'b1, 2'd0, 32'h0000_0100);   // dropped, -> 0xC
        drive(1'b0, 1'b1, 1'b1, 2'd0, 32'hFFFF_FFF0);   // 0xC -> slot 0x10, target 0
        drive(1'b0, 1'b1, 1'b0, 2'd0, 32'h0);
        checks++;
        if (bus.pc_out !== 32'h0 || bus.in_delay_slot !== 1'b0) begin
            errors++;
            $display("FAIL b2b_target: got pc=%h ds=%b expected 00000000/0", bus.pc_out, bus.in_delay_slot);
        end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
            if (o !== e) begin errors++; $display("FAIL back_to_back: got %h expected %h", o, e); end
        end
    endtask

    task automatic test_align();
        snap_t e, o;
        logic [31:0] want_pc;
        logic        want_fault;
        drive(1'b0, 1'b1, 1'b1, 2'd2, 32'h0040_0002);
        want_fault = CHK;
        checks++;
        if (bus.align_fault !== want_fault || bus.pc_out !== 32'h0000_0004) begin
            errors++;
            $display("FAIL align_first: got pc=%h fault=%b expected 00000004/%b",
                     bus.pc_out, bus.align_fault, want_fault);
        end
        drive(1'b0, 1'b1, 1'b0, 2'd0, 32'h0);
        want_pc = CHK ? 32'h0000_0008 : 32'h0040_0002;
        checks++;
        if (bus.pc_out !== want_pc || bus.align_fault !== 1'b0) begin
            errors++;
            $display("FAIL align_second: got pc=%h fault=%b expected %h/0",
                     bus.pc_out, bus.align_fault, want_pc);
        end
        drive(1'b0, 1'b1, 1'b0, 2'd0, 32'h0);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
            if (o !== e) begin errors++; $display("FAIL align: got %h expected %h", o, e); end
        end
    endtask

    initial begin
        reset                = 1'b1;
        bus.pc_en            = 1'b0;
        bus.redirect_valid   = 1'b0;
        bus.redirect_kind    = 2'd0;
        bus.redirect_operand = 32'h0;
        test_reset();
        test_sequential();
        test_branch();
        test_jump();
        test_jreg_stall();
        test_ignored();
        test_reset_pending();
        test_wrap();
        test_back_to_back();
        test_align();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
